// File: rtl/sig_hys_pkg.sv
// Shared defaults and helpers for the sig_hys_bank debouncer.
package sig_hys_pkg;

  localparam int unsigned DEF_NUM_CH      = 8;
  localparam int unsigned DEF_SYNC_STAGES = 3;
  localparam int unsigned DEF_CNT_W       = 16;
  localparam logic        DEF_RESET_VAL   = 1'b0;

  // Threshold arguments are carried at 32 bits, so CNT_W may be at most 32.
  localparam int unsigned MAX_CNT_W       = 32;

  // A threshold of zero behaves like one: the change needs at least one
  // full cycle of persistence.
  function automatic logic [MAX_CNT_W-1:0] clamp_min1(input logic [MAX_CNT_W-1:0] x);
    return (x == '0) ? MAX_CNT_W'(1) : x;
  endfunction

endpackage

// File: rtl/sig_hys_ch.sv
// One debounce channel: input synchroniser, persistence counter, filtered
// level and rise/fall pulse flops.
module sig_hys_ch
  import sig_hys_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter logic        RESET_VAL   = DEF_RESET_VAL
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] on_cnt_i,
  input  logic [CNT_W-1:0] off_cnt_i,
  input  logic             dir_i,
  output logic             fil_o,
  output logic             rise_o,
  output logic             fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   fil_q, fil_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  logic                   s;
  logic [MAX_CNT_W-1:0]   thr;
  logic [CNT_W:0]         cnt_inc;
  logic                   reached;

  // Synchroniser: plain shift register, last stage is the sampled level.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) sync_q <= {SYNC_STAGES{RESET_VAL}};
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], dir_i};
  end

  // Threshold selection and persistence-count next-state logic.
  always_comb begin
    s       = sync_q[SYNC_STAGES-1];
    thr     = fil_q ? clamp_min1(MAX_CNT_W'(off_cnt_i))
                    : clamp_min1(MAX_CNT_W'(on_cnt_i));
    // One extra bit so the all-ones threshold is reachable without wrap.
    cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
    // Compared with >= so a threshold lowered mid-count fires at once.
    reached = ((MAX_CNT_W+1)'(cnt_inc) >= {1'b0, thr});
    cnt_d   = '0;
    fil_d   = fil_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (enable_i && (s != fil_q)) begin
      if (reached) begin
        fil_d  = s;
        rise_d = s;
        fall_d = ~s;
      end else begin
        cnt_d  = cnt_inc[CNT_W-1:0];
      end
    end
  end

  // Counter, filtered level and pulse registers.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cnt_q  <= '0;
      fil_q  <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      fil_q  <= fil_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign fil_o  = fil_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/sig_hys_bank.sv
// Multi-channel debouncer with independent rise/fall hysteresis and
// one-cycle change pulses; one sig_hys_ch per channel.
module sig_hys_bank
  import sig_hys_pkg::*;
#(
  parameter int unsigned NUM_CH      = DEF_NUM_CH,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter logic        RESET_VAL   = DEF_RESET_VAL
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              enable,
  input  logic [CNT_W-1:0]  on_cnt,
  input  logic [CNT_W-1:0]  off_cnt,
  input  logic [NUM_CH-1:0] dir_sig,
  output logic [NUM_CH-1:0] fil_sig,
  output logic [NUM_CH-1:0] rise_pls,
  output logic [NUM_CH-1:0] fall_pls,
  output logic              changed
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sig_hys_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .RESET_VAL   (RESET_VAL)
    ) u_ch (
      .clk       (clk),
      .reset_b   (reset_b),
      .enable_i  (enable),
      .on_cnt_i  (on_cnt),
      .off_cnt_i (off_cnt),
      .dir_i     (dir_sig[g]),
      .fil_o     (fil_sig[g]),
      .rise_o    (rise_pls[g]),
      .fall_o    (fall_pls[g])
    );
  end

  // Any channel changing this cycle.
  always_comb begin
    changed = |(rise_pls | fall_pls);
  end

endmodule

// File: tb/tb_sig_hys_bank.sv
module tb_sig_hys_bank;

  logic        clk;
  logic        reset_b;
  logic        enable;
  logic [15:0] on_cnt;
  logic [15:0] off_cnt;
  logic [7:0]  dir_sig;
  logic [7:0]  fil_sig;
  logic [7:0]  rise_pls;
  logic [7:0]  fall_pls;
  logic        changed;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  sig_hys_bank #(
    .NUM_CH      (8),
    .SYNC_STAGES (3),
    .CNT_W       (16),
    .RESET_VAL   (1'b0)
  ) dut (
    .clk      (clk),
    .reset_b  (reset_b),
    .enable   (enable),
    .on_cnt   (on_cnt),
    .off_cnt  (off_cnt),
    .dir_sig  (dir_sig),
    .fil_sig  (fil_sig),
    .rise_pls (rise_pls),
    .fall_pls (fall_pls),
    .changed  (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; return at the following falling edge.
  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  logic seen;

  initial begin
    reset_b = 1'b0;
    enable  = 1'b1;
    on_cnt  = 16'd7;
    off_cnt = 16'd10;
    dir_sig = 8'h00;

    // Reset with inputs toggling
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      dir_sig = ~dir_sig;
      tick(1);
    end
    chk("rst_fil", fil_sig, 8'h00);
    chk("rst_rise", rise_pls, 8'h00);
    chk("rst_fall", fall_pls, 8'h00);
    chk("rst_changed", {7'd0, changed}, 8'h00);
    dir_sig = 8'h00;
    tick(2);
    reset_b = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      seen = seen | changed;
    end
    chk("idle_changed", {7'd0, seen}, 8'h00);

    // Clean rise on ch0: fil changes at edge 3+7 = 10
    dir_sig = 8'h01;
    tick(9);
    chk("rise0_e9_fil", fil_sig, 8'h00);
    tick(1);
    chk("rise0_e10_fil", fil_sig, 8'h01);
    chk("rise0_e10_rise", rise_pls, 8'h01);
    chk("rise0_e10_fall", fall_pls, 8'h00);
    chk("rise0_e10_changed", {7'd0, changed}, 8'h01);
    tick(1);
    chk("rise0_e11_rise", rise_pls, 8'h00);
    chk("rise0_e11_changed", {7'd0, changed}, 8'h00);

    // Glitch of 5 cycles on ch2 is rejected
    dir_sig = 8'h05;
    tick(5);
    dir_sig = 8'h01;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      seen = seen | rise_pls[2];
    end
    chk("glitch_rise2", {7'd0, seen}, 8'h00);
    chk("glitch_fil", fil_sig, 8'h01);

    // Held high for 7+ cycles on ch2: rises at edge 10
    dir_sig = 8'h05;
    tick(9);
    chk("rise2_e9_fil", fil_sig, 8'h01);
    tick(1);
    chk("rise2_e10_fil", fil_sig, 8'h05);
    chk("rise2_e10_rise", rise_pls, 8'h04);

    // ch0: low 9, high 1, low 10 -> fall at 10th cycle of second run (edge 23)
    dir_sig = 8'h04;
    tick(9);
    dir_sig = 8'h05;
    tick(1);
    dir_sig = 8'h04;
    tick(12);
    chk("asym_e22_fil", fil_sig, 8'h05);
    chk("asym_e22_fall", fall_pls, 8'h00);
    tick(1);
    chk("asym_e23_fil", fil_sig, 8'h04);
    chk("asym_e23_fall", fall_pls, 8'h01);
    chk("asym_e23_changed", {7'd0, changed}, 8'h01);

    // on_cnt = 0 behaves as 1: ch1 rises at edge 4
    on_cnt  = 16'd0;
    dir_sig = 8'h06;
    tick(3);
    chk("zero_e3_fil", fil_sig, 8'h04);
    tick(1);
    chk("zero_e4_fil", fil_sig, 8'h06);
    chk("zero_e4_rise", rise_pls, 8'h02);

    // ch3: on_cnt 20, lowered to 3 once cnt = 5 -> toggle next edge
    on_cnt  = 16'd20;
    dir_sig = 8'h0E;
    tick(8);
    chk("lower_e8_fil", fil_sig, 8'h06);
    on_cnt = 16'd3;
    tick(1);
    chk("lower_e9_fil", fil_sig, 8'h0E);
    chk("lower_e9_rise", rise_pls, 8'h08);
    on_cnt = 16'd7;

    // ch4: enable dropped mid-count, full count needed after re-enable
    dir_sig = 8'h1E;
    tick(6);
    enable = 1'b0;
    tick(5);
    chk("dis_fil", fil_sig, 8'h0E);
    chk("dis_rise", rise_pls, 8'h00);
    enable = 1'b1;
    tick(6);
    chk("reen_6_fil", fil_sig, 8'h0E);
    tick(1);
    chk("reen_7_fil", fil_sig, 8'h1E);
    chk("reen_7_rise", rise_pls, 8'h10);

    // Simultaneous fall on ch1..ch4 (off_cnt = 10 -> edge 13)
    dir_sig = 8'h00;
    tick(12);
    chk("allfall_e12_fil", fil_sig, 8'h1E);
    tick(1);
    chk("allfall_e13_fil", fil_sig, 8'h00);
    chk("allfall_e13_fall", fall_pls, 8'h1E);
    chk("allfall_e13_changed", {7'd0, changed}, 8'h01);
    tick(1);
    chk("allfall_e14_changed", {7'd0, changed}, 8'h00);

    // All channels stepped together
    dir_sig = 8'hFF;
    tick(9);
    chk("allrise_e9_fil", fil_sig, 8'h00);
    tick(1);
    chk("allrise_e10_fil", fil_sig, 8'hFF);
    chk("allrise_e10_rise", rise_pls, 8'hFF);
    chk("allrise_e10_changed", {7'd0, changed}, 8'h01);
    tick(1);
    chk("allrise_e11_rise", rise_pls, 8'h00);
    chk("allrise_e11_changed", {7'd0, changed}, 8'h00);
    chk("allrise_e11_fil", fil_sig, 8'hFF);

    // Reset asserted mid-count: immediate reset values, no pulse
    dir_sig = 8'h00;
    tick(5);
    #1 reset_b = 1'b0;
    #1;
    chk("midrst_fil", fil_sig, 8'h00);
    chk("midrst_fall", fall_pls, 8'h00);
    chk("midrst_changed", {7'd0, changed}, 8'h00);
    tick(15);
    reset_b = 1'b1;
    tick(3);
    chk("midrst_after_fil", fil_sig, 8'h00);
    chk("midrst_after_fall", fall_pls, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sig_hys_bank.md
# sig_hys_bank

Parametrised multi-channel debouncer with independent rise/fall hysteresis and edge-event outputs. Each of NUM_CH asynchronous inputs passes through a SYNC_STAGES-deep synchroniser, then a per-channel persistence counter. The filtered output changes only after the synchronised input has differed from it for a programmable number of consecutive cycles. The block sits between board-level inputs (switches, open-drain status lines) and the register/interrupt logic, which consumes the filtered levels and the one-cycle change pulses.

## Interface
- NUM_CH, 8, number of independent channels (≥1)
- SYNC_STAGES, 3, synchroniser depth (≥2)
- CNT_W, 16, width of persistence counters and threshold inputs
- RESET_VAL, 1'b0, value of every sync flop and fil_sig after reset
- clk  input  1  single clock
- reset_b  input  1  asynchronous, active-low reset
- enable  input  1  1 = filtering active; 0 = counters held at 0, outputs frozen
- on_cnt  input  CNT_W  consecutive cycles needed for 0→1 (static between changes; 0 treated as 1)
- off_cnt  input  CNT_W  consecutive cycles needed for 1→0 (0 treated as 1)
- dir_sig  input  NUM_CH  unfiltered asynchronous inputs
- fil_sig  output  NUM_CH  filtered levels, registered
- rise_pls  output  NUM_CH  one-cycle pulse on filtered 0→1
- fall_pls  output  NUM_CH  one-cycle pulse on filtered 1→0
- changed  output  1  OR-reduction of rise_pls | fall_pls

## Operation
- Per channel: s = last stage of sync chain (plain shift, no AND-gating).
- Threshold T = (fil_sig==0) ? max(on_cnt,1) : max(off_cnt,1).
- Each clk, enable=1:
  - s == fil_sig → cnt <= 0.
  - s != fil_sig and cnt+1 < T → cnt <= cnt+1.
  - s != fil_sig and cnt+1 ≥ T → fil_sig <= s, cnt <= 0, matching pulse <= 1.
- enable=0: cnt <= 0, fil_sig holds, pulses 0; sync chain keeps shifting.
- Comparison uses ≥, so lowering a threshold mid-count below cnt+1 causes a toggle on the next cycle; the counter never wraps.
- Counter width CNT_W; cnt+1 is computed in CNT_W+1 bits so T = 2^CNT_W−1 is reachable without overflow.
- Channels are fully independent; simultaneous toggles on several channels are all reported the same cycle.

## Timing
- Reset (async assert, sync release): sync flops = RESET_VAL, fil_sig = {NUM_CH{RESET_VAL}}, cnt = 0, rise_pls = fall_pls = 0, changed = 0.
- Latency for a clean step sampled at edge 1: s changes at edge SYNC_STAGES; fil_sig changes at edge SYNC_STAGES+T. Default rise (T=7): edge 10; default fall (T=10): edge 13.
- rise_pls/fall_pls are high exactly the one cycle after the edge at which fil_sig takes its new value, coincident with that new value; changed is combinational from them.
- A glitch whose synchronised width is < T cycles produces no output change and no pulse; counter returns to 0.
- A reversal during counting clears cnt; the full T is needed again.
- Reset asserted mid-count: immediate return to reset values, no pulse emitted.

## Structure
- Package sig_hys_pkg: default parameter constants and threshold-clamp function (max(x,1)).
- Sub-module sig_hys_ch: one channel (sync chain, counter, fil/pulse flops) with scalar ports plus shared enable/thresholds; the top instantiates NUM_CH copies in a generate loop and forms changed.

## Test plan
- Reset: reset_b=0 with dir_sig toggling → fil_sig=0, pulses=0; release, dir_sig=0 → no pulses for 50 cycles.
- Clean rise, defaults (on_cnt=7): dir_sig[0] 0→1 before edge 1 → fil_sig[0]=1 after edge 10, rise_pls[0]=1 for one cycle, changed=1; other channels unchanged.
- Glitch rejection: dir_sig[2] high for 5 cycles then low (on_cnt=7) → fil_sig[2] stays 0, no pulse; high for 7 cycles → rises at edge 10.
- Asymmetric hysteresis: after fil=1, dir_sig low 9 cycles, high 1, low 10 (off_cnt=10) → fall occurs only after the second low run, at its 10th synchronised cycle.
- Threshold edge cases: on_cnt=0 → rise at edge SYNC_STAGES+1; mid-count (cnt=5) lower on_cnt 20→3 → toggle next cycle; enable=0 mid-count → no change, cnt restarts on re-enable.
- All channels stepped together → all fil_sig bits and rise_pls bits assert the same cycle; changed high one cycle.
